tlb_lookup_arbiter: RTL and testbench

- Shares the core's single TLB search port between two requesters: instruction fetch (IF, req 0) and data memory stage (DM, req 1).
- Sits between fetch_stage / mem stage and the TLB array.
- Registers the winning virtual address, samples the combinational TLB result one cycle later, and returns it to the owner as a one-cycle response pulse.
- Handles replay on TLB write, flush on commit, and anti-starvation of fetch.

---
 rtl/tlb_lookup_arbiter_pkg.sv | 20 ++
 rtl/tlb_lookup_arbiter.sv | 156 +++++++++++++++
 tb/tb_tlb_lookup_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tlb_lookup_arbiter_pkg.sv
// ============================================================================
// Module : tlb_lookup_arbiter_pkg
// Brief  : Owner encodings and FSM state type for the TLB search-port arbiter
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tlb_lookup_arbiter_pkg;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_DM = 1'b1;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOOKUP = 1'b1
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/tlb_lookup_arbiter.sv
// ============================================================================
// Module : tlb_lookup_arbiter
// Brief  : Shares one TLB search port between fetch (IF) and data (DM) stages
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tlb_lookup_arbiter
  import tlb_lookup_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_vaddr,
  output logic        if_ack,
  output logic        if_resp_valid,
  output logic [31:0] if_paddr,
  output logic        if_miss,
  output logic        if_invalid,
  output logic [2:0]  if_cattr,
  input  logic        dm_req,
  input  logic [31:0] dm_vaddr,
  output logic        dm_ack,
  output logic        dm_resp_valid,
  output logic [31:0] dm_paddr,
  output logic        dm_miss,
  output logic        dm_invalid,
  output logic        dm_dirty,
  output logic [2:0]  dm_cattr,
  output logic [31:0] tlb_vaddr,
  input  logic [31:0] tlb_paddr,
  input  logic        tlb_miss,
  input  logic        tlb_invalid,
  input  logic        tlb_dirty,
  input  logic [2:0]  tlb_cattr,
  input  logic        tlb_write,
  input  logic        commit_i,
  output logic [31:0] perfcnt_tlb_conflict
);

  localparam int                  STREAK_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic                r_owner;
  logic [31:0]         r_tlb_vaddr;
  logic [STREAK_W-1:0] r_streak;
  logic [31:0]         r_perf;

  logic        r_if_resp_valid, r_if_miss, r_if_invalid;
  logic [31:0] r_if_paddr;
  logic [2:0]  r_if_cattr;
  logic        r_dm_resp_valid, r_dm_miss, r_dm_invalid, r_dm_dirty;
  logic [31:0] r_dm_paddr;
  logic [2:0]  r_dm_cattr;

  logic w_grant_ok, w_if_wins, w_grant, w_if_ack, w_dm_ack, w_complete;

  // A TLB write in LOOKUP replays the in-flight search, so the port stays busy.
  assign w_grant_ok = resetn && !commit_i && ((r_state == ARB_IDLE) || !tlb_write);
  assign w_if_wins  = if_req && (!dm_req || (r_streak == STREAK_MAX));
  assign w_grant    = w_grant_ok && (if_req || dm_req);
  assign w_if_ack   = w_grant && w_if_wins;
  assign w_dm_ack   = w_grant && !w_if_wins;
  assign w_complete = (r_state == ARB_LOOKUP) && !tlb_write && !commit_i;

  always_comb begin
    w_state_nxt = ARB_IDLE;
    if (commit_i)
      w_state_nxt = ARB_IDLE;
    else if ((r_state == ARB_LOOKUP) && tlb_write)
      w_state_nxt = ARB_LOOKUP;
    else if (w_grant)
      w_state_nxt = ARB_LOOKUP;
  end

  always_ff @(posedge clk) begin
    if (!resetn)
      r_state <= ARB_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_owner         <= REQ_IF;
      r_tlb_vaddr     <= '0;
      r_streak        <= '0;
      r_perf          <= '0;
      r_if_resp_valid <= 1'b0;
      r_if_paddr      <= '0;
      r_if_miss       <= 1'b0;
      r_if_invalid    <= 1'b0;
      r_if_cattr      <= '0;
      r_dm_resp_valid <= 1'b0;
      r_dm_paddr      <= '0;
      r_dm_miss       <= 1'b0;
      r_dm_invalid    <= 1'b0;
      r_dm_dirty      <= 1'b0;
      r_dm_cattr      <= '0;
    end else begin
      if (w_grant) begin
        r_tlb_vaddr <= w_if_wins ? if_vaddr : dm_vaddr;
        r_owner     <= w_if_wins ? REQ_IF : REQ_DM;
      end

      r_if_resp_valid <= w_complete && (r_owner == REQ_IF);
      r_dm_resp_valid <= w_complete && (r_owner == REQ_DM);

      if (w_complete && (r_owner == REQ_IF)) begin
        r_if_paddr   <= tlb_paddr;
        r_if_miss    <= tlb_miss;
        r_if_invalid <= tlb_invalid;
        r_if_cattr   <= tlb_cattr;
      end
      if (w_complete && (r_owner == REQ_DM)) begin
        r_dm_paddr   <= tlb_paddr;
        r_dm_miss    <= tlb_miss;
        r_dm_invalid <= tlb_invalid;
        r_dm_dirty   <= tlb_dirty;
        r_dm_cattr   <= tlb_cattr;
      end

      // Streak only measures DM wins while fetch is actually waiting.
      if (commit_i || !if_req || w_if_ack)
        r_streak <= '0;
      else if (w_dm_ack && (r_streak != STREAK_MAX))
        r_streak <= r_streak + 1'b1;

      if (w_grant && if_req && dm_req)
        r_perf <= r_perf + 32'd1;
    end
  end

  assign if_ack               = w_if_ack;
  assign dm_ack               = w_dm_ack;
  assign tlb_vaddr            = r_tlb_vaddr;
  assign perfcnt_tlb_conflict = r_perf;
  assign if_resp_valid        = r_if_resp_valid;
  assign if_paddr             = r_if_paddr;
  assign if_miss              = r_if_miss;
  assign if_invalid           = r_if_invalid;
  assign if_cattr             = r_if_cattr;
  assign dm_resp_valid        = r_dm_resp_valid;
  assign dm_paddr             = r_dm_paddr;
  assign dm_miss              = r_dm_miss;
  assign dm_invalid           = r_dm_invalid;
  assign dm_dirty             = r_dm_dirty;
  assign dm_cattr             = r_dm_cattr;

endmodule

`default_nettype wire

// File: tb/tb_tlb_lookup_arbiter.sv
// ============================================================================
// Module : tb_tlb_lookup_arbiter
// Brief  : Randomized self-checking bench for tlb_lookup_arbiter
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_tlb_lookup_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0;
  logic [31:0] if_vaddr = '0, dm_vaddr = '0;
  logic        tlb_write = 1'b0, commit_i = 1'b0;
  logic        if_ack, if_resp_valid, if_miss, if_invalid;
  logic [31:0] if_paddr;
  logic [2:0]  if_cattr;
  logic        dm_ack, dm_resp_valid, dm_miss, dm_invalid, dm_dirty;
  logic [31:0] dm_paddr;
  logic [2:0]  dm_cattr;
  logic [31:0] tlb_vaddr, tlb_paddr, perfcnt_tlb_conflict;
  logic        tlb_miss, tlb_invalid, tlb_dirty;
  logic [2:0]  tlb_cattr;

  int checks = 0;
  int errors = 0;
  int gen    = 0;

  // Fake TLB contents change on every write so replayed results are distinguishable.
  function automatic logic [38:0] xlate(input logic [31:0] va, input int g);
    logic [31:0] gg;
    gg = 32'(g);
    xlate[38:7] = va ^ (gg * 32'h9E37_79B9);
    xlate[6]    = ^va[15:12] ^ gg[0];
    xlate[5]    = va[16];
    xlate[4]    = va[17] ^ gg[1];
    xlate[3:0]  = {1'b0, va[20:18] + gg[2:0]};
  endfunction

  logic [38:0] w_x;
  assign w_x         = xlate(tlb_vaddr, gen);
  assign tlb_paddr   = w_x[38:7];
  assign tlb_miss    = w_x[6];
  assign tlb_invalid = w_x[5];
  assign tlb_dirty   = w_x[4];
  assign tlb_cattr   = w_x[2:0];

  tlb_lookup_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_vaddr(if_vaddr), .if_ack(if_ack), .if_resp_valid(if_resp_valid),
    .if_paddr(if_paddr), .if_miss(if_miss), .if_invalid(if_invalid), .if_cattr(if_cattr),
    .dm_req(dm_req), .dm_vaddr(dm_vaddr), .dm_ack(dm_ack), .dm_resp_valid(dm_resp_valid),
    .dm_paddr(dm_paddr), .dm_miss(dm_miss), .dm_invalid(dm_invalid), .dm_dirty(dm_dirty),
    .dm_cattr(dm_cattr), .tlb_vaddr(tlb_vaddr), .tlb_paddr(tlb_paddr), .tlb_miss(tlb_miss),
    .tlb_invalid(tlb_invalid), .tlb_dirty(tlb_dirty), .tlb_cattr(tlb_cattr),
    .tlb_write(tlb_write), .commit_i(commit_i), .perfcnt_tlb_conflict(perfcnt_tlb_conflict)
  );

  always #5 clk = ~clk;

  // Reference model: one optional in-flight lookup plus expected output values.
  bit          m_busy = 0;
  bit          m_owner_dm = 0;
  logic [31:0] m_vaddr = '0;
  int          m_streak = 0;
  int          forced_if = 0;
  int          resp_seen = 0;
  logic [31:0] e_perf = '0, e_tlb_vaddr = '0;
  logic        e_if_ack = 0, e_dm_ack = 0;
  logic        e_if_rv = 0, e_dm_rv = 0;
  logic [38:0] e_if_res = '0, e_dm_res = '0;

  task automatic compute_acks();
    bit can, if_wins;
    can     = resetn && !commit_i && (!m_busy || !tlb_write);
    if_wins = if_req && (!dm_req || m_streak >= LIMIT);
    e_if_ack = can && (if_req || dm_req) && if_wins;
    e_dm_ack = can && (if_req || dm_req) && !if_wins;
  endtask

  task automatic model_edge();
    if (!resetn) begin
      m_busy = 0; m_owner_dm = 0; m_streak = 0;
      e_perf = '0; e_tlb_vaddr = '0; e_if_rv = 0; e_dm_rv = 0;
      e_if_res = '0; e_dm_res = '0;
      return;
    end
    e_if_rv = 0;
    e_dm_rv = 0;
    if (m_busy && !tlb_write && !commit_i) begin
      resp_seen++;
      if (m_owner_dm) begin e_dm_rv = 1; e_dm_res = xlate(m_vaddr, gen); end
      else            begin e_if_rv = 1; e_if_res = xlate(m_vaddr, gen); end
    end
    if ((e_if_ack || e_dm_ack) && if_req && dm_req) e_perf = e_perf + 32'd1;
    if (e_if_ack && dm_req && m_streak >= LIMIT) forced_if++;
    if (commit_i || !if_req || e_if_ack) m_streak = 0;
    else if (e_dm_ack && m_streak < LIMIT) m_streak++;
    if (commit_i) m_busy = 0;
    else if (m_busy && tlb_write) m_busy = 1;
    else if (e_if_ack || e_dm_ack) begin
      m_busy = 1;
      m_owner_dm = e_dm_ack;
      m_vaddr = e_dm_ack ? dm_vaddr : if_vaddr;
      e_tlb_vaddr = m_vaddr;
    end else m_busy = 0;
    if (tlb_write) gen++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("if_ack", 32'(if_ack), 32'(e_if_ack));
    chk("dm_ack", 32'(dm_ack), 32'(e_dm_ack));
    chk("if_resp_valid", 32'(if_resp_valid), 32'(e_if_rv));
    chk("dm_resp_valid", 32'(dm_resp_valid), 32'(e_dm_rv));
    chk("if_paddr", if_paddr, e_if_res[38:7]);
    chk("if_miss", 32'(if_miss), 32'(e_if_res[6]));
    chk("if_invalid", 32'(if_invalid), 32'(e_if_res[5]));
    chk("if_cattr", 32'(if_cattr), 32'(e_if_res[2:0]));
    chk("dm_paddr", dm_paddr, e_dm_res[38:7]);
    chk("dm_miss", 32'(dm_miss), 32'(e_dm_res[6]));
    chk("dm_invalid", 32'(dm_invalid), 32'(e_dm_res[5]));
    chk("dm_dirty", 32'(dm_dirty), 32'(e_dm_res[4]));
    chk("dm_cattr", 32'(dm_cattr), 32'(e_dm_res[2:0]));
    chk("tlb_vaddr", tlb_vaddr, e_tlb_vaddr);
    chk("perfcnt", perfcnt_tlb_conflict, e_perf);
  endtask

  initial begin
    bit          if_pend, dm_pend;
    logic [31:0] if_va, dm_va;
    int          p_req, p_wr, p_cm;
    if_pend = 0; dm_pend = 0; if_va = '0; dm_va = '0;

    for (int cyc = 0; cyc < 1600; cyc++) begin
      @(posedge clk);
      #1;
      model_edge();
      if (e_if_ack) if_pend = 0;
      if (e_dm_ack) dm_pend = 0;

      // Phase 1: saturated requests to exercise starvation; phase 2: full mix.
      if (cyc < 250) begin p_req = 95; p_wr = 0; p_cm = 0; end
      else if (cyc < 500) begin p_req = 90; p_wr = 20; p_cm = 0; end
      else begin p_req = 60; p_wr = 15; p_cm = 6; end

      if (!if_pend && $urandom_range(99) < p_req) begin
        if_pend = 1;
        if_va = {12'h004, $urandom_range(32'hFFFF), 4'h0};
      end else if (if_pend && cyc >= 500 && $urandom_range(99) < 3) if_pend = 0;
      if (!dm_pend && $urandom_range(99) < p_req) begin
        dm_pend = 1;
        dm_va = {1'b1, 31'($urandom)};
      end else if (dm_pend && cyc >= 500 && $urandom_range(99) < 3) dm_pend = 0;

      resetn    = !(cyc < 3 || (cyc >= 1000 && cyc < 1002));
      if_req    = if_pend;
      if_vaddr  = if_va;
      dm_req    = dm_pend;
      dm_vaddr  = dm_va;
      tlb_write = ($urandom_range(99) < p_wr);
      commit_i  = ($urandom_range(99) < p_cm);
      compute_acks();

      @(negedge clk);
      check_all();
    end

    chk("forced_if_seen", 32'(forced_if > 0), 32'd1);
    chk("responses_seen", 32'(resp_seen > 100), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
